// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encodings, FSM states and defaults for the ALU/MDU
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // op = {m_ext, alt, funct3}
    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b01000;
    localparam logic [4:0] OP_SLL    = 5'b00001;
    localparam logic [4:0] OP_SLT    = 5'b00010;
    localparam logic [4:0] OP_SLTU   = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SRL    = 5'b00101;
    localparam logic [4:0] OP_SRA    = 5'b01101;
    localparam logic [4:0] OP_OR     = 5'b00110;
    localparam logic [4:0] OP_AND    = 5'b00111;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    function automatic logic op_illegal(input logic [4:0] op);
        return op[3] && (op[4] || !((op[2:0] == 3'b000) || (op[2:0] == 3'b101)));
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - one-bit-per-clock shift-add multiplier and restoring divider
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic            busy,
    input  logic            is_div,
    input  logic            sel_hi,
    input  logic            a_signed,
    input  logic            b_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] res
);

    localparam int SHAMT_W = $clog2(XLEN);

    // acc holds {hi, lo} for multiply and {remainder, quotient} for divide
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic is_div_q, is_div_d, sel_hi_q, sel_hi_d, neg_q, neg_d, neg_a_q, neg_a_d;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, trial, diff;
    logic              ge;
    logic [2*XLEN-1:0] step_val, prod_s;
    logic [XLEN-1:0]   quo, rem, quo_s, rem_s;

    always_comb begin
        a_neg = a_signed & a[XLEN-1];
        b_neg = b_signed & b[XLEN-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;

        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        trial   = acc_q[2*XLEN-1:XLEN-1];
        diff    = trial - {1'b0, opb_q};
        ge      = ~diff[XLEN];
        step_val = is_div_q ? {(ge ? diff[XLEN-1:0] : trial[XLEN-1:0]), acc_q[XLEN-2:0], ge}
                            : {mul_sum, acc_q[XLEN-1:1]};

        // final value is taken from the last step's next-state so it lands with done
        prod_s = neg_q ? (~step_val + 1'b1) : step_val;
        quo    = step_val[XLEN-1:0];
        rem    = step_val[2*XLEN-1:XLEN];
        quo_s  = neg_q ? (~quo + 1'b1) : quo;
        rem_s  = neg_a_q ? (~rem + 1'b1) : rem;
        if (is_div_q) res = sel_hi_q ? rem_s : quo_s;
        else          res = sel_hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];

        done = busy && (cnt_q == SHAMT_W'(XLEN-1));

        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        sel_hi_d = sel_hi_q;
        neg_d    = neg_q;
        neg_a_d  = neg_a_q;
        if (start) begin
            acc_d    = {{XLEN{1'b0}}, a_mag};
            opb_d    = b_mag;
            is_div_d = is_div;
            sel_hi_d = sel_hi;
            neg_d    = a_neg ^ b_neg;
            neg_a_d  = a_neg;
        end else if (busy) begin
            acc_d = step_val;
        end

        if (start || flush) cnt_d = '0;
        else if (busy)      cnt_d = cnt_q + SHAMT_W'(1);
        else                cnt_d = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sel_hi_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_a_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sel_hi_q <= sel_hi_d;
            neg_q    <= neg_d;
            neg_a_q  <= neg_a_d;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - RV32/64 integer ALU with iterative M-extension unit and ready/valid handshake
module alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            br_eq,
    output logic            br_lt,
    output logic            br_ltu,
    output logic            op_err
);

    localparam int SHAMT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            br_eq_q, br_eq_d, br_lt_q, br_lt_d, br_ltu_q, br_ltu_d;
    logic            op_err_q, op_err_d;
    logic            accept, mdu_done;
    logic [XLEN-1:0] mdu_res;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] spec_res;

    function automatic logic [XLEN-1:0] base_alu(input logic [4:0] o,
                                                 input logic [XLEN-1:0] x,
                                                 input logic [XLEN-1:0] y);
        logic [SHAMT_W-1:0] sh;
        sh = y[SHAMT_W-1:0];
        case (o)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_SLL:  return x << sh;
            OP_SLT:  return {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU: return {{(XLEN-1){1'b0}}, (x < y)};
            OP_XOR:  return x ^ y;
            OP_SRL:  return x >> sh;
            OP_SRA:  return $unsigned($signed(x) >>> sh);
            OP_OR:   return x | y;
            OP_AND:  return x & y;
            default: return '0;
        endcase
    endfunction

    // divide-by-zero and signed overflow bypass the iterative unit
    assign div_zero = (b == '0);
    assign div_ovf  = !op[0] && (a == MOST_NEG) && (b == '1);
    assign special  = op[2] && (div_zero || div_ovf);
    assign spec_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        br_eq_d  = br_eq_q;
        br_lt_d  = br_lt_q;
        br_ltu_d = br_ltu_q;
        op_err_d = op_err_q;
        accept   = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        accept   = 1'b1;
                        br_eq_d  = (a == b);
                        br_lt_d  = ($signed(a) < $signed(b));
                        br_ltu_d = (a < b);
                        op_err_d = 1'b0;
                        if (op_illegal(op)) begin
                            result_d = '0;
                            op_err_d = 1'b1;
                            state_d  = S_DONE;
                        end else if (op[4] && !special) begin
                            state_d = S_BUSY;
                        end else begin
                            result_d = op[4] ? spec_res : base_alu(op, a, b);
                            state_d  = S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    if (mdu_done) begin
                        result_d = mdu_res;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            br_eq_q  <= 1'b0;
            br_lt_q  <= 1'b0;
            br_ltu_q <= 1'b0;
            op_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            br_eq_q  <= br_eq_d;
            br_lt_q  <= br_lt_d;
            br_ltu_q <= br_ltu_d;
            op_err_q <= op_err_d;
        end
    end

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .start    (accept),
        .busy     (state_q == S_BUSY),
        .is_div   (op[2]),
        .sel_hi   (op[2] ? op[1] : (op[1:0] != 2'b00)),
        .a_signed (op[2] ? ~op[0] : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10))),
        .b_signed (op[2] ? ~op[0] : (op[1:0] == 2'b01)),
        .a        (a),
        .b        (b),
        .done     (mdu_done),
        .res      (mdu_res)
    );

    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign br_eq     = br_eq_q;
    assign br_lt     = br_lt_q;
    assign br_ltu    = br_ltu_q;
    assign op_err    = op_err_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed scoreboard bench for alu_mdu
module tb_alu_mdu;
    import alu_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [4:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        in_ready, out_valid, br_eq, br_lt, br_ltu, op_err;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        logic        eq, lt, ltu, err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0, fails = 0;

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu), .op_err(op_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        longint sx, sy, uy, p;
        logic [63:0] pu;
        logic ovf;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        uy = longint'({32'b0, y});
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        e.eq = (x == y); e.lt = ($signed(x) < $signed(y)); e.ltu = (x < y);
        e.err = 1'b0; e.lat = 1;
        case (o)
            5'b00000: e.res = x + y;
            5'b01000: e.res = x - y;
            5'b00001: e.res = x << y[4:0];
            5'b00010: e.res = {31'b0, e.lt};
            5'b00011: e.res = {31'b0, e.ltu};
            5'b00100: e.res = x ^ y;
            5'b00101: e.res = x >> y[4:0];
            5'b01101: e.res = $signed(x) >>> y[4:0];
            5'b00110: e.res = x | y;
            5'b00111: e.res = x & y;
            5'b10000: begin p = sx * sy; e.res = p[31:0]; end
            5'b10001: begin p = sx * sy; e.res = p[63:32]; end
            5'b10010: begin p = sx * uy; e.res = p[63:32]; end
            5'b10011: begin pu = {32'b0, x} * {32'b0, y}; e.res = pu[63:32]; end
            5'b10100: e.res = (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(sx / sy);
            5'b10101: e.res = (y == 0) ? 32'hFFFF_FFFF : x / y;
            5'b10110: e.res = (y == 0) ? x : ovf ? 32'h0 : 32'(sx % sy);
            5'b10111: e.res = (y == 0) ? x : x % y;
            default: begin e.res = '0; e.err = 1'b1; end
        endcase
        if (o[4] && !o[3] && !(o[2] && ((y == 0) || (!o[0] && ovf)))) e.lat = 33;
        return e;
    endfunction

    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input int hold);
        exp_t got;
        int n;
        sb.push_back(model(o, x, y));
        out_ready = (hold == 0);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        n = 1;
        #1 in_valid = 1'b0; a = $urandom; b = $urandom; op = 5'($urandom);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            n++;
        end
        chk("out_valid_seen", out_valid, 1);
        got = sb.pop_front();
        chk("latency", n, got.lat);
        chk("result", result, got.res);
        chk("br_eq", br_eq, got.eq);
        chk("br_lt", br_lt, got.lt);
        chk("br_ltu", br_ltu, got.ltu);
        chk("op_err", op_err, got.err);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_result", result, got.res);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    task automatic launch(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic expect_silence(input string tag);
        int n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk(tag, n, 0);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {br_eq, br_lt, br_ltu, op_err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(OP_ADD,    32'h7FFF_FFFF, 32'h0000_0001, 0);
        issue(OP_SUB,    32'h0000_0003, 32'h0000_0005, 0);
        issue(OP_SLT,    32'hFFFF_FFFE, 32'h0000_0001, 0);
        issue(OP_SLTU,   32'hFFFF_FFFE, 32'h0000_0001, 0);
        issue(OP_SLL,    32'h0000_0001, 32'h0000_003F, 0);
        issue(OP_SRL,    32'h8000_0000, 32'h0000_0021, 0);
        issue(OP_SRA,    32'hF000_0000, 32'h0000_0024, 0);
        issue(OP_XOR,    32'hA5A5_A5A5, 32'hFFFF_0000, 0);
        issue(OP_OR,     32'h1234_0000, 32'h0000_5678, 0);
        issue(OP_AND,    32'hDEAD_BEEF, 32'h0F0F_0F0F, 0);
        issue(5'b01001,  32'h1234_5678, 32'h1234_5678, 0);
        issue(5'b11000,  32'h0000_0005, 32'h0000_0003, 0);
        issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 0);
        issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(OP_MUL,    32'hFFFF_FFF9, 32'h0001_0003, 0);
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(OP_DIVU,   32'h0000_0005, 32'h0000_0000, 0);
        issue(OP_REMU,   32'h0000_0005, 32'h0000_0000, 0);
        issue(OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 0);
        issue(OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 0);
        issue(OP_REMU,   32'hFFFF_FFF9, 32'h0000_0010, 0);
        issue(OP_ADD,    32'h0000_0003, 32'h0000_0003, 5);
        issue(OP_XOR,    32'h0000_00F0, 32'h0000_000F, 0);

        // flush partway through an iterative op
        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        expect_silence("flush_no_output");

        // flush beats a simultaneous accept
        @(negedge clk);
        op = OP_ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_in_ready", in_ready, 1);
        expect_silence("flush_accept_no_output");

        // asynchronous reset partway through an iterative op
        launch(OP_DIVU, 32'd7, 32'd100);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_flags", {br_eq, br_lt, br_ltu, op_err}, 0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        expect_silence("rst_no_output");

        issue(OP_DIVU, 32'd100, 32'd7, 0);
        chk("divu_100_7", result, 32'd14);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (legal: 8, 16, 32, 64).
REQ-002 SHALL derive local parameter SHAMT_W = $clog2(XLEN), shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous abort of any operation in flight.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  block can accept a request.
REQ-008 SHALL have port op  input  5  operation code: op[4] selects M-extension, op[3] selects sub/sra, op[2:0] is RISC-V funct3.
REQ-009 SHALL have ports a, b  input  XLEN  operands.
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port result  output  XLEN  registered result.
REQ-013 SHALL have ports br_eq, br_lt, br_ltu  output  1 each  a==b, signed a<b, unsigned a<b.
REQ-014 SHALL have port op_err  output  1  the accepted op code was illegal.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE with rst_n high.
REQ-016 SHALL accept on in_valid && in_ready, capturing op, a and b; base ops and M special cases go IDLE->DONE, other M ops go IDLE->BUSY.
REQ-017 SHALL support base ops ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND with RISC-V semantics; shifts use b[SHAMT_W-1:0] only.
REQ-018 SHALL support M ops MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU with RISC-V semantics, using one iteration per clock for exactly XLEN clocks in BUSY, then BUSY->DONE.
REQ-019 SHALL raise out_valid 1 edge after accept for base ops and special cases, and XLEN+1 edges after accept for iterative M ops.
REQ-020 SHALL treat division by zero as a special case: quotient all ones, remainder = a.
REQ-021 SHALL treat signed overflow (a = most-negative, b = -1) as a special case: DIV returns a, REM returns 0.
REQ-022 SHALL compute br_eq, br_lt and br_ltu from the captured operands for every op and present them with result.
REQ-023 SHALL treat op[4]=0 with op[3]=1 and funct3 not 000/101, or op[4]=1 with op[3]=1, as illegal: result 0, op_err 1, single-cycle latency.
REQ-024 SHALL, in DONE, hold result, flags and op_err stable until out_valid && out_ready, then go to IDLE; the next accept is possible one edge later.
REQ-025 SHALL, when flush is high, go to IDLE on the next edge from any state, drop out_valid and discard the operation; flush wins over a simultaneous accept.
REQ-026 SHALL clear the iteration counter on every accept and on every flush.

Reset
REQ-027 SHALL, while rst_n is low, immediately force: state IDLE, out_valid 0, result 0, all flags 0, op_err 0, counter 0, in_ready 0.
REQ-028 SHALL abort any BUSY/DONE operation on reset with no output.

Structure
REQ-029 SHALL place the op encodings, the FSM state enum and the default XLEN in shared package alu_pkg.
REQ-030 SHALL place the iterative shift-add multiplier and restoring divider in sub-module mdu_iter (start, XLEN-cycle done, signed-correction inputs).

Verification
REQ-031 ADD a=0x7FFFFFFF b=0x00000001 -> result 0x80000000, out_valid 1 edge after accept, br_eq=0, br_lt=0, br_ltu=0.
REQ-032 MULH a=0x80000000 b=0x80000000 -> result 0x40000000 at edge 33; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000 and REM -> 0; DIVU 5/0 -> 0xFFFFFFFF and REMU -> 5; all at 1-edge latency.
REQ-034 SRA a=0xF0000000 b=0x00000024 -> 0xFF000000 (only b[4:0]=4 used); op=5'b01001 -> op_err=1, result 0.
REQ-035 out_ready held low 5 cycles in DONE -> result stable, in_ready 0; release -> IDLE; next request accepted 1 edge later.
REQ-036 flush at BUSY cycle 10, and separately rst_n low mid-BUSY -> no out_valid, outputs per REQ-025/REQ-027; following DIVU 100/7 -> result 14.
